// File: rtl/mvau_sched_pkg.sv
// Shared types and helpers for the MVAU weight-memory scheduler.
//   sched_state_t : scheduler FSM state
//   clog2_min1    : address/counter width, never narrower than one bit
package mvau_sched_pkg;

  typedef enum logic [0:0] {IDLE, RUN} sched_state_t;

  function automatic int unsigned clog2_min1(input int unsigned x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/mvau_fold_counter.sv
// Wrapping fold counter, chained last -> en to build nested loops.
//   aclk, aresetn : clock, async active-low reset
//   en            : step the counter
//   clr           : synchronous clear back to 0
//   cnt           : current count, 0..MAX-1
//   last          : en && cnt == MAX-1 (this step wraps, i.e. carries outward)
module mvau_fold_counter
  import mvau_sched_pkg::*;
#(
  parameter int unsigned MAX    = 2,
  parameter int unsigned CNT_BW = clog2_min1(MAX)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              en,
  input  logic              clr,
  output logic [CNT_BW-1:0] cnt,
  output logic              last
);

  localparam logic [CNT_BW-1:0] CntMax = CNT_BW'(MAX - 1);

  logic [CNT_BW-1:0] cnt_q;

  assign cnt  = cnt_q;
  // With MAX == 1 the count is stuck at 0 and every step is a wrap.
  assign last = en && (cnt_q == CntMax);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last ? '0 : cnt_q + CNT_BW'(1);
    end
  end

endmodule

// File: rtl/mvau_wmem_sched.sv
// Weight-memory scheduler for one MVAU batch unit.
// Walks the weight memory over SF (inner) x NF x NUM_VEC, drives the input
// buffer (capture on the first NF pass, replay afterwards) and tags each
// delivered weight with fold-boundary flags.
//   aclk, aresetn   : clock, async active-low reset
//   start           : pulse to begin an image (ignored while busy)
//   act_valid       : activation word available (only consulted when nf_cnt == 0)
//   out_stall       : downstream cannot take a weight this cycle
//   wmem_addr       : weight-memory read address (combinational)
//   inbuf_addr      : input-buffer slot (= sf_cnt)
//   inbuf_wr        : capture the stream word into inbuf_addr
//   act_ready       : stream word consumed (== inbuf_wr)
//   w_valid         : memory output word is valid
//   sf/nf/vec_last  : fold-boundary flags aligned with w_valid
//   busy            : image in progress
//   done            : one-cycle pulse with the final weight
module mvau_wmem_sched
  import mvau_sched_pkg::*;
#(
  parameter int unsigned SF            = 2,
  parameter int unsigned NF            = 2,
  parameter int unsigned NUM_VEC       = 4,
  parameter int unsigned WMEM_DEPTH    = SF * NF,
  parameter int unsigned WMEM_ADDR_BW  = clog2_min1(WMEM_DEPTH),
  parameter int unsigned INBUF_ADDR_BW = clog2_min1(SF)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic                     act_valid,
  input  logic                     out_stall,
  output logic [WMEM_ADDR_BW-1:0]  wmem_addr,
  output logic [INBUF_ADDR_BW-1:0] inbuf_addr,
  output logic                     inbuf_wr,
  output logic                     act_ready,
  output logic                     w_valid,
  output logic                     sf_last,
  output logic                     nf_last,
  output logic                     vec_last,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned NF_BW  = clog2_min1(NF);
  localparam int unsigned VEC_BW = clog2_min1(NUM_VEC);

  localparam logic [WMEM_ADDR_BW-1:0]  AddrMax = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
  localparam logic [INBUF_ADDR_BW-1:0] SfMax   = INBUF_ADDR_BW'(SF - 1);
  localparam logic [NF_BW-1:0]         NfMax   = NF_BW'(NF - 1);
  localparam logic [VEC_BW-1:0]        VecMax  = VEC_BW'(NUM_VEC - 1);

  sched_state_t state_q;

  logic [WMEM_ADDR_BW-1:0]  addr_cnt_q;
  logic [WMEM_ADDR_BW-1:0]  issued_q;
  logic [INBUF_ADDR_BW-1:0] sf_cnt;
  logic [NF_BW-1:0]         nf_cnt;
  logic [VEC_BW-1:0]        vec_cnt;

  logic sf_wrap, nf_wrap, vec_wrap;
  logic first_pass, advance, clr;
  logic sf_last_d, nf_last_d, vec_last_d;
  logic w_valid_q, sf_last_q, nf_last_q, vec_last_q, done_q;

  assign first_pass = (nf_cnt == '0);
  // Replay passes never wait on the input stream.
  assign advance    = (state_q == RUN) && !out_stall && (first_pass ? act_valid : 1'b1);
  assign clr        = (state_q == IDLE) && start;

  mvau_fold_counter #(.MAX(SF), .CNT_BW(INBUF_ADDR_BW)) u_sf_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (advance),
    .clr     (clr),
    .cnt     (sf_cnt),
    .last    (sf_wrap)
  );

  mvau_fold_counter #(.MAX(NF), .CNT_BW(NF_BW)) u_nf_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (sf_wrap),
    .clr     (clr),
    .cnt     (nf_cnt),
    .last    (nf_wrap)
  );

  mvau_fold_counter #(.MAX(NUM_VEC), .CNT_BW(VEC_BW)) u_vec_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (nf_wrap),
    .clr     (clr),
    .cnt     (vec_cnt),
    .last    (vec_wrap)
  );

  assign sf_last_d  = (sf_cnt == SfMax);
  assign nf_last_d  = (nf_cnt == NfMax) && sf_last_d;
  assign vec_last_d = (vec_cnt == VecMax) && nf_last_d;

  // Re-present the last issued address when nothing advances, so the
  // memory's registered output stays frozen under stall.
  assign wmem_addr  = advance ? addr_cnt_q : issued_q;
  assign inbuf_addr = sf_cnt;
  assign inbuf_wr   = advance && first_pass;
  assign act_ready  = inbuf_wr;

  assign w_valid  = w_valid_q;
  assign sf_last  = sf_last_q;
  assign nf_last  = nf_last_q;
  assign vec_last = vec_last_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      addr_cnt_q <= '0;
      issued_q   <= '0;
      w_valid_q  <= 1'b0;
      sf_last_q  <= 1'b0;
      nf_last_q  <= 1'b0;
      vec_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= vec_wrap;

      case (state_q)
        IDLE: if (start) state_q <= RUN;
        RUN:  if (vec_wrap) state_q <= IDLE;
      endcase

      if (advance) begin
        addr_cnt_q <= (addr_cnt_q == AddrMax) ? '0 : addr_cnt_q + WMEM_ADDR_BW'(1);
        issued_q   <= addr_cnt_q;
        w_valid_q  <= 1'b1;
        sf_last_q  <= sf_last_d;
        nf_last_q  <= nf_last_d;
        vec_last_q <= vec_last_d;
      end else if (!out_stall) begin
        w_valid_q  <= 1'b0;
        sf_last_q  <= 1'b0;
        nf_last_q  <= 1'b0;
        vec_last_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mvau_wmem_sched.md
# mvau_wmem_sched

Weight-memory scheduler for one MVAU batch unit. It walks the weight memory across the synapse fold (SF) and the neuron fold (NF) for every input vector of an image. It also tells the input buffer when to capture a new activation word and when to replay a stored one. Delivered weights are tagged with fold-boundary flags, and a downstream stall freezes the weight word presented on the single-cycle-latency weight memory.

## Interface
- SF, 2, synapse fold = MatrixW/SIMD (≥1)
- NF, 2, neuron fold = MatrixH/PE (≥1)
- NUM_VEC, 4, input vectors per image (OFMDim², ≥1)
- WMEM_DEPTH, SF*NF, weight memory depth
- WMEM_ADDR_BW, $clog2(WMEM_DEPTH) (min 1), address width
- aclk  in  1  main clock; all state on rising edge
- aresetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin an image
- act_valid  in  1  input stream has an activation word (used on first NF pass only)
- out_stall  in  1  downstream cannot accept a weight this cycle
- wmem_addr  out  WMEM_ADDR_BW  address to weight memory (combinational)
- inbuf_addr  out  $clog2(SF) (min 1)  input-buffer slot = sf_cnt
- inbuf_wr  out  1  capture stream word into inbuf_addr (first pass, on advance)
- act_ready  out  1  stream word consumed (== inbuf_wr)
- w_valid  out  1  weight word on memory output is valid
- sf_last, nf_last, vec_last  out  1 each  flags aligned with w_valid
- busy  out  1  state==RUN
- done  out  1  one-cycle pulse after last weight issued

## Operation
- States: IDLE → RUN on start. RUN → IDLE on advance with sf, nf and vec counters all at max; done pulses the next cycle.
- start is ignored while in RUN.
- first_pass = (nf_cnt==0).
- advance = RUN && !out_stall && (first_pass ? act_valid : 1).
- act_ready = inbuf_wr = advance && first_pass.
- Counters nest as sf_cnt (inner, 0..SF-1), nf_cnt (0..NF-1), vec_cnt (0..NUM_VEC-1). All step on advance only, and each wraps to 0 when it carries.
- addr_cnt increments on advance and wraps WMEM_DEPTH-1 → 0. It equals nf_cnt*SF+sf_cnt at all times.
- issued_q <= addr_cnt on advance.
- wmem_addr = advance ? addr_cnt : issued_q. This keeps the memory re-reading the last issued word whenever nothing is issued, so its registered output is frozen under stall.
- w_valid / flags, registered:
  - advance → w_valid=1, flags captured from counters: sf_last=(sf_cnt==SF-1), nf_last=(nf_cnt==NF-1 && sf_last), vec_last=(vec_cnt==NUM_VEC-1 && nf_last).
  - out_stall → hold.
  - otherwise → w_valid=0, flags=0.
- SF=1 or NF=1 are legal: the corresponding counter is constant 0 and its "last" compare is always true.
- Reset values: state IDLE, all counters 0, issued_q 0, w_valid, sf_last, nf_last, vec_last, done all 0. With no advance, wmem_addr therefore reads 0.
- Reset mid-image aborts immediately. No done pulse; the next start restarts at address 0.

## Timing
- Weight latency: advance in cycle t → w_valid and matching memory data in t+1.
- Throughput: one weight per cycle with no stall and act_valid high.
- act_valid is ignored in replay passes (nf_cnt>0). Replays never wait on the stream.
- There are combinational paths from act_valid and out_stall to wmem_addr, act_ready and inbuf_wr; this is intended.
- out_stall and act_valid low together: no advance. w_valid holds if out_stall is high, else clears.
- done is asserted in the cycle after the final advance, coincident with w_valid and vec_last.

## Structure
- Package mvau_sched_pkg holds:
  - the state enum `sched_state_t {IDLE, RUN}`
  - a function computing max(1,$clog2(x)) for the address widths
- Sub-module mvau_fold_counter: parameter MAX, ports en and clr, outputs cnt and last (en && cnt==MAX-1). It is instantiated three times and chained by last → en.

## Test plan
Parameters for all scenarios: SF=2, NF=2, NUM_VEC=2.
- Reset then idle: all outputs 0, wmem_addr=0; act_valid=1 with no start gives act_ready=0.
- start with act_valid and out_stall tied: wmem_addr issues 0,1,2,3,0,1,2,3 on consecutive cycles.
  - inbuf_wr is high only on addresses 0 and 1 of each vector.
  - sf_last is high on w_valid for the words read at addresses 1 and 3.
  - nf_last is high on the word read at address 3.
  - vec_last and done come one cycle after the 8th issue.
- act_valid low during first pass at sf_cnt=1: address stays 0 and no advance. When act_valid rises, issue resumes at address 1; replay addresses 2 and 3 then issue without act_valid.
- out_stall held 3 cycles right after address 2 is issued: w_valid stays 1, wmem_addr stays 2, memory data stays word 2. Address 3 issues on the first unstalled cycle.
- Reset asserted mid-image at address 2: outputs clear asynchronously. A new start issues from address 0 with inbuf_wr=1.
- Variant SF=1, NF=1, NUM_VEC=3: every issue has sf_last, nf_last and inbuf_wr high; vec_last is high on the 3rd issue.
